// File: rtl/plot_selector.sv
// Three-button plot/page selector: debounced Next/Previous/Auto-play presses
// step a plot index and drive a registered one-hot enable bus.

module plot_selector_btn #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic sysclk,
  input  logic rst,
  input  logic btn_i,
  output logic press_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          db_state_q, db_state_d;
  logic          db_prev_q;
  logic [CW-1:0] db_cnt_q, db_cnt_d;

  // A level change is accepted only after DEBOUNCE_CYCLES consecutive
  // synchronised samples disagree with the current debounced level.
  always_comb begin
    db_state_d = db_state_q;
    db_cnt_d   = '0;
    if (sync2_q != db_state_q) begin
      if (db_cnt_q == CNT_LAST) begin
        db_state_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_state_q <= 1'b0;
      db_prev_q  <= 1'b0;
      db_cnt_q   <= '0;
    end else begin
      sync1_q    <= btn_i;
      sync2_q    <= sync1_q;
      db_state_q <= db_state_d;
      db_prev_q  <= db_state_q;
      db_cnt_q   <= db_cnt_d;
    end
  end

  assign press_o = db_state_q & ~db_prev_q;

endmodule

module plot_selector #(
  parameter int NUM_PLOTS       = 4,
  parameter int AUTO_PERIOD     = 268435456,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int WRAP            = 1,
  localparam int IW             = $clog2(NUM_PLOTS)
) (
  input  logic                 sysclk,
  input  logic                 rst,
  input  logic                 Bt_Next,
  input  logic                 Bt_Pre,
  input  logic                 Bt_Auto,
  output logic [NUM_PLOTS-1:0] Enable_SW,
  output logic [IW-1:0]        Address,
  output logic                 Is_Auto,
  output logic                 Auto_Tick
);

  localparam int AW = $clog2(AUTO_PERIOD);
  localparam logic [AW-1:0] AUTO_LAST = AW'(AUTO_PERIOD - 1);
  localparam logic [IW-1:0] ADDR_LAST = IW'(NUM_PLOTS - 1);

  logic next_p, pre_p, auto_p;

  logic [IW-1:0]        addr_q, addr_d, addr_inc, addr_dec;
  logic [NUM_PLOTS-1:0] en_q, en_d;
  logic                 is_auto_q, is_auto_d;
  logic                 tick_q, tick_d;
  logic [AW-1:0]        auto_cnt_q, auto_cnt_d;
  logic                 manual, tick_due;

  plot_selector_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_next (
    .sysclk(sysclk), .rst(rst), .btn_i(Bt_Next), .press_o(next_p)
  );
  plot_selector_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_pre (
    .sysclk(sysclk), .rst(rst), .btn_i(Bt_Pre), .press_o(pre_p)
  );
  plot_selector_btn #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_auto (
    .sysclk(sysclk), .rst(rst), .btn_i(Bt_Auto), .press_o(auto_p)
  );

  always_comb begin
    addr_inc = addr_q + 1'b1;
    addr_dec = addr_q - 1'b1;
    if (addr_q == ADDR_LAST) begin
      addr_inc = (WRAP != 0) ? '0 : ADDR_LAST;
    end
    if (addr_q == '0) begin
      addr_dec = (WRAP != 0) ? ADDR_LAST : '0;
    end
  end

  // Manual presses win over the auto tick; a tick that would run past the
  // last plot in saturate mode ends auto-play instead.
  always_comb begin
    manual    = next_p | pre_p;
    tick_due  = is_auto_q && (auto_cnt_q == AUTO_LAST);
    addr_d    = addr_q;
    is_auto_d = is_auto_q ^ auto_p;
    tick_d    = 1'b0;
    if (next_p && !pre_p) begin
      addr_d = addr_inc;
    end else if (pre_p && !next_p) begin
      addr_d = addr_dec;
    end else if (!manual && tick_due && !auto_p) begin
      if (WRAP == 0 && addr_q == ADDR_LAST) begin
        is_auto_d = 1'b0;
      end else begin
        addr_d = addr_inc;
        tick_d = 1'b1;
      end
    end
    if (!is_auto_q || !is_auto_d || manual || tick_due) begin
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  always_comb begin
    en_d = '0;
    for (int i = 0; i < NUM_PLOTS; i++) begin
      en_d[i] = (addr_q == IW'(i));
    end
  end

  always_ff @(posedge sysclk) begin
    if (rst) begin
      addr_q     <= '0;
      en_q       <= NUM_PLOTS'(1);
      is_auto_q  <= 1'b0;
      tick_q     <= 1'b0;
      auto_cnt_q <= '0;
    end else begin
      addr_q     <= addr_d;
      en_q       <= en_d;
      is_auto_q  <= is_auto_d;
      tick_q     <= tick_d;
      auto_cnt_q <= auto_cnt_d;
    end
  end

  assign Address   = addr_q;
  assign Enable_SW = en_q;
  assign Is_Auto   = is_auto_q;
  assign Auto_Tick = tick_q;

endmodule

// File: tb/tb_plot_selector.sv
// Bench for plot_selector: three configurations share the same buttons and are
// compared every cycle against an event-level reference model.

module tb_plot_selector;

  localparam int DB = 4;
  localparam int AP = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bn = 1'b0, bp = 1'b0, ba = 1'b0;

  logic [3:0] en_a, en_b;
  logic [4:0] en_c;
  logic [1:0] ad_a, ad_b;
  logic [2:0] ad_c;
  logic au_a, au_b, au_c, tk_a, tk_b, tk_c;

  always #5 clk = ~clk;

  plot_selector #(.NUM_PLOTS(4), .AUTO_PERIOD(AP), .DEBOUNCE_CYCLES(DB), .WRAP(1)) u_a (
    .sysclk(clk), .rst(rst), .Bt_Next(bn), .Bt_Pre(bp), .Bt_Auto(ba),
    .Enable_SW(en_a), .Address(ad_a), .Is_Auto(au_a), .Auto_Tick(tk_a)
  );
  plot_selector #(.NUM_PLOTS(4), .AUTO_PERIOD(AP), .DEBOUNCE_CYCLES(DB), .WRAP(0)) u_b (
    .sysclk(clk), .rst(rst), .Bt_Next(bn), .Bt_Pre(bp), .Bt_Auto(ba),
    .Enable_SW(en_b), .Address(ad_b), .Is_Auto(au_b), .Auto_Tick(tk_b)
  );
  plot_selector #(.NUM_PLOTS(5), .AUTO_PERIOD(AP), .DEBOUNCE_CYCLES(DB), .WRAP(1)) u_c (
    .sysclk(clk), .rst(rst), .Bt_Next(bn), .Bt_Pre(bp), .Bt_Auto(ba),
    .Enable_SW(en_c), .Address(ad_c), .Is_Auto(au_c), .Auto_Tick(tk_c)
  );

  int np[3] = '{4, 4, 5};
  int wr[3] = '{1, 0, 1};
  int m_addr[3], m_en[3], m_auto[3], m_tick[3], m_due[3];
  bit lvl[3], prs[3];
  bit rawh[3][$];
  bit win[3][$];
  int edge_n = 0;
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int stepf(input int a, input int d, input int n, input int w);
    int t;
    if (w != 0) return (a + d + n) % n;
    t = a + d;
    if (t < 0) return 0;
    if (t > n - 1) return n - 1;
    return t;
  endfunction

  task automatic model_reset();
    for (int j = 0; j < 3; j++) begin
      m_addr[j] = 0; m_en[j] = 1; m_auto[j] = 0; m_tick[j] = 0; m_due[j] = 0;
    end
    for (int b = 0; b < 3; b++) begin
      lvl[b] = 1'b0; prs[b] = 1'b0;
      rawh[b] = {1'b0, 1'b0};
      win[b].delete();
    end
  endtask

  task automatic model_edge(input bit in_n, input bit in_p, input bit in_a);
    bit manual, due, was, s, all_diff;
    bit ins[3];
    ins[0] = in_n; ins[1] = in_p; ins[2] = in_a;
    edge_n++;
    manual = prs[0] | prs[1];
    for (int j = 0; j < 3; j++) begin
      m_en[j]   = 1 << m_addr[j];
      m_tick[j] = 0;
      was = (m_auto[j] != 0);
      due = was && (edge_n == m_due[j]);
      if (prs[0] && !prs[1]) m_addr[j] = stepf(m_addr[j], 1, np[j], wr[j]);
      else if (prs[1] && !prs[0]) m_addr[j] = stepf(m_addr[j], -1, np[j], wr[j]);
      else if (!manual && due && !prs[2]) begin
        if (wr[j] == 0 && m_addr[j] == np[j] - 1) m_auto[j] = 0;
        else begin
          m_addr[j] = stepf(m_addr[j], 1, np[j], wr[j]);
          m_tick[j] = 1;
        end
      end
      if (prs[2]) m_auto[j] = was ? 0 : 1;
      if ((prs[2] && !was) || manual || m_tick[j] != 0) m_due[j] = edge_n + AP;
    end
    // Each button: two-sample delay, then a level is accepted once DB fresh samples disagree.
    for (int b = 0; b < 3; b++) begin
      s = rawh[b].pop_front();
      rawh[b].push_back(ins[b]);
      prs[b] = 1'b0;
      win[b].push_back(s);
      if (win[b].size() > DB) void'(win[b].pop_front());
      if (win[b].size() == DB) begin
        all_diff = 1'b1;
        for (int i = 0; i < DB; i++) if (win[b][i] == lvl[b]) all_diff = 1'b0;
        if (all_diff) begin
          lvl[b] = ~lvl[b];
          prs[b] = lvl[b];
          win[b].delete();
        end
      end
    end
  endtask

  task automatic check_all();
    int o_addr[3], o_en[3], o_auto[3], o_tick[3];
    o_addr = '{int'(ad_a), int'(ad_b), int'(ad_c)};
    o_en   = '{int'(en_a), int'(en_b), int'(en_c)};
    o_auto = '{int'(au_a), int'(au_b), int'(au_c)};
    o_tick = '{int'(tk_a), int'(tk_b), int'(tk_c)};
    for (int j = 0; j < 3; j++) begin
      chk($sformatf("addr%0d", j), o_addr[j], m_addr[j]);
      chk($sformatf("en%0d", j),   o_en[j],   m_en[j]);
      chk($sformatf("auto%0d", j), o_auto[j], m_auto[j]);
      chk($sformatf("tick%0d", j), o_tick[j], m_tick[j]);
    end
  endtask

  task automatic cyc(input bit r, input bit n, input bit p, input bit a);
    @(negedge clk);
    rst = r; bn = n; bp = p; ba = a;
    @(posedge clk);
    if (r) model_reset();
    else model_edge(n, p, a);
    #1;
    check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit [2:0] m, g;
    int dur;
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);

    // Next held after reset: one step, Enable_SW moves on the 8th edge.
    for (int i = 1; i <= 20; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      if (i == 7) chk("en_before", int'(en_a), 1);
      if (i == 8) chk("en_step", int'(en_a), 2);
    end
    idle(20);
    chk("held_once", int'(ad_a), 1);

    // Short Pre glitch ignored; then two clean Pre presses.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle(20);
    chk("glitch", int'(ad_a), 1);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
      idle(12);
    end
    chk("wrap_a", int'(ad_a), 3);
    chk("wrap_en_a", int'(en_a), 8);
    chk("sat_b", int'(ad_b), 0);
    chk("wrap_c", int'(ad_c), 4);

    // Auto-play on; saturating instance stops at its last plot.
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1);
    idle(60);
    chk("sat_off_b", int'(au_b), 0);
    chk("sat_end_b", int'(ad_b), 3);
    chk("auto_on_c", int'(au_c), 1);

    // Manual Next mid-interval, then Next+Pre together.
    idle(3);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle(25);
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1, 1'b0);
    idle(25);

    // Reset while Next is being debounced: no stale press afterwards.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle(20);
    chk("rst_addr", int'(ad_a), 0);
    chk("rst_auto", int'(au_a), 0);
    chk("rst_en", int'(en_a), 1);

    // Random segments with occasional glitches and resets.
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 49) == 0) begin
        for (int i = 0; i < 2; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      m   = 3'($urandom_range(0, 7));
      dur = $urandom_range(1, 9);
      for (int i = 0; i < dur; i++) begin
        g = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
        cyc(1'b0, m[0] ^ g[0], m[1] ^ g[1], m[2] ^ g[2]);
      end
      idle($urandom_range(0, 30));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
